// File: rtl/gate_tester2.sv
// gate_tester2 -- on-board self-test sequencer for a 2-input combinational gate.
//
// On an accepted start the block drives the gate inputs through 00, 01, 10, 11.
// It holds each vector for SETTLE_CYCLES cycles and then spends one sample cycle
// capturing gate_y. After the fourth vector it reports the captured truth table,
// the per-vector mismatch mask against EXPECT, and a pass flag.
//
// Parameters
//   SETTLE_CYCLES : cycles each vector is driven before sampling (1..255)
//   EXPECT        : expected gate output per vector, bit index {a,b}
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   start    in   run request, sampled only while idle
//   gate_a   out  registered drive to gate input a
//   gate_b   out  registered drive to gate input b
//   gate_y   in   gate output under test
//   busy     out  high while vectors are being applied/sampled
//   done     out  one-cycle pulse at the end of a run
//   pass     out  last completed run had no mismatches
//   result   out  captured gate_y per vector, bit index {a,b}
//   err_mask out  result ^ EXPECT, accumulated per vector
module gate_tester2 #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  EXPECT        = 4'b1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [3:0] err_mask
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] vec;
  logic [3:0] err_upd;

  // Mismatch mask including the vector being sampled this cycle; lets pass be
  // registered on the same edge that captures the last vector.
  always_comb begin
    err_upd      = err_mask;
    err_upd[vec] = gate_y ^ EXPECT[vec];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      vec      <= '0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      result   <= '0;
      err_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= SETTLE;
            vec      <= '0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
            cnt      <= CNT_LOAD;
            busy     <= 1'b1;
            pass     <= 1'b0;
            result   <= '0;
            err_mask <= '0;
          end
        end

        SETTLE: begin
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        SAMPLE: begin
          result[vec] <= gate_y;
          err_mask    <= err_upd;
          if (vec == 2'd3) begin
            state  <= DONE;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= (err_upd == '0);
          end else begin
            state  <= SETTLE;
            vec    <= vec + 2'd1;
            // Drive the next vector, i.e. {a,b} = vec + 1.
            {gate_a, gate_b} <= vec + 2'd1;
            cnt    <= CNT_LOAD;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_tester2.md
# gate_tester2

Self-checking sequencer for any 2-input combinational gate in the lab designs (andgate2 and its siblings). On `start` it drives the gate's two inputs through all four combinations. It waits a programmable settle time per vector, samples the gate output, and compares the result against an expected truth table. It then reports the captured table, a per-vector error mask and a pass flag, and acts as the on-board test controller between the switches/LEDs and a gate under test.

## Interface
- `SETTLE_CYCLES`, default 4: clock cycles spent driving each vector before sampling. Legal range 1..255.
- `EXPECT`, default 4'b1000: expected output per vector. Bit index is {a,b}; the default is the AND truth table.

- `clk` — in, 1: single clock, rising edge.
- `reset_n` — in, 1: synchronous, active-low reset. Sampled on `clk` rising edge.
- `start` — in, 1: request a test run. Sampled only in IDLE.
- `gate_a` — out, 1: registered drive to gate input a.
- `gate_b` — out, 1: registered drive to gate input b.
- `gate_y` — in, 1: gate output under test.
- `busy` — out, 1: high while a run is in progress (SETTLE/SAMPLE).
- `done` — out, 1: one-cycle pulse when a run completes.
- `pass` — out, 1: 1 when the last completed run had no mismatches.
- `result` — out, 4: captured `gate_y` per vector; bit index {a,b}.
- `err_mask` — out, 4: `result ^ EXPECT`, accumulated per vector.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0, `gate_a`=`gate_b`=0.
  - SETTLE: drive the current vector and count.
  - SAMPLE: capture `gate_y`.
  - DONE: one cycle, `done`=1.
- IDLE with `start`=1 at an edge:
  - Go to SETTLE.
  - `vec`=0; {`gate_a`,`gate_b`}=2'b00.
  - Settle counter loaded with `SETTLE_CYCLES`-1.
  - `result`, `err_mask` and `pass` cleared to 0.
- SETTLE: decrement the counter each edge. When the counter is 0, go to SAMPLE.
- SAMPLE, at its closing edge:
  - `result[vec]` <= `gate_y`.
  - `err_mask[vec]` <= `gate_y ^ EXPECT[vec]`.
  - If `vec`==3, go to DONE and drive `gate_a`=`gate_b`=0.
  - Otherwise `vec`<=`vec`+1, {`gate_a`,`gate_b`} <= the new `vec`, reload the counter, and return to SETTLE.
- DONE:
  - `pass` <= (final `err_mask`==0); registered on DONE entry and visible while `done`=1.
  - Next edge goes to IDLE unconditionally.
- `vec` is 2 bits. It stops at 3 and never wraps within a run.
- `start` is ignored in SETTLE, SAMPLE and DONE. Holding `start` high restarts the run from the first IDLE cycle after DONE.
- `result`, `err_mask` and `pass` hold their values until the next accepted `start` or reset.
- Reset (`reset_n`=0 at any edge, including mid-run):
  - Next state is IDLE.
  - All outputs go to 0: `gate_a`, `gate_b`, `busy`, `done`, `pass`, `result`, `err_mask`.
  - The counter and `vec` go to 0.
  - An aborted run produces no `done` pulse.

## Timing
- Edge numbering: E0 is the edge at which `start` is accepted.
- Each vector occupies `SETTLE_CYCLES`+1 cycles. For S=`SETTLE_CYCLES`, vector k is sampled at edge E(k+1)(S+1).
- With S=4: vectors 00, 01, 10, 11 are sampled at E5, E10, E15 and E20.
- DONE state and `done`=1 run from E4(S+1) to E4(S+1)+1. For S=4 that is E20..E21.
- `busy`=1 from E0 to E4(S+1), then 0 in DONE and IDLE.
- `gate_a`/`gate_b` change only at E0 and at SAMPLE edges. `gate_y` therefore sees at least S stable cycles before sampling.
- Total run latency from E0 to the `done` rising edge: 4(S+1) cycles.
- All outputs are registered. There is no combinational path from `gate_y` or `start` to any output.

## Test plan
- AND model on `gate_y`, defaults, start pulse at E0:
  - Inputs step 00→01→10→11 at E0/E5/E10/E15.
  - `done`=1 during E20..E21; `result`=4'b1000, `err_mask`=4'b0000, `pass`=1.
- OR model, EXPECT=4'b1000: `result`=4'b1110, `err_mask`=4'b0110, `pass`=0.
- `gate_y` stuck at 1: `result`=4'b1111, `err_mask`=4'b0111, `pass`=0.
- `start` held high continuously, S=4:
  - The second run is accepted at E22.
  - `result`/`err_mask`/`pass` clear at E22; `done` pulses once per run.
- `reset_n`=0 at E7 mid-run: at E8 every output is 0 and the state is IDLE. No `done` pulse follows, and `start` is accepted normally afterwards.
- SETTLE_CYCLES=1 with AND model:
  - Samples at E2/E4/E6/E8; `done`=1 during E8..E9; `pass`=1.
  - `start` pulses during the run are ignored.
